vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Schedules the single asynchronous-SRAM VRAM port between the display fetch path and queued CPU framebuffer writes.
- Time is divided by the 3-bit character sequence count: two slots per 8-pixel character are always reserved for the display read, and the remaining slots drain a small write FIFO.
- Sits between the bus-snoop capture logic (write requester) and the VRAM pins, with the pixel shifter as fetch consumer.

Parameters:
FIFO_DEPTH, 4, write queue entries; power of 2, at least 2
ADDR_W, 15, VRAM address width
DATA_W, 8, VRAM data width

Ports:
pixClock  in  1  25.175MHz pixel clock; all state on rising edge
reset  in  1  synchronous, active-high reset
seq  in  3  character sequence count, increments every pixClock
fetchEn  in  1  1 = active display, seq 0-1 reserved for fetch
fetchAddr  in  ADDR_W  display byte address, sampled at edge ending seq 7
fetchData  out  DATA_W  last fetched byte
fetchValid  out  1  one-cycle pulse, fetchData updated
wrReq  in  1  write request from snoop logic
wrAddr  in  ADDR_W  write address
wrData  in  DATA_W  write data
wrFull  out  1  registered; FIFO full
ovfFlag  out  1  sticky; a request was dropped
vramAddr  out  ADDR_W  VRAM address
vramDataOut  out  DATA_W  VRAM write data
vramDataOE  out  1  1 = drive VRAM data bus
vramDataIn  in  DATA_W  VRAM read data
nvramWE  out  1  VRAM write strobe, active low
nvramOE  out  1  VRAM output enable, active low

Behaviour:
- All outputs registered.
- Decode uses next = seq+1 (mod 8), so registered outputs align with the current seq value. "During seq N" below means the cycle in which seq==N.
- Reset values: vramAddr=0, vramDataOut=0, vramDataOE=0, nvramWE=1, nvramOE=1, fetchData=0, fetchValid=0, wrFull=0, ovfFlag=0, FIFO empty, state IDLE.
- States: IDLE, FETCH, TURN, WSETUP, WSTROBE, WHOLD. State is re-derived from seq every cycle, so a seq discontinuity re-aligns within one cycle.
- seq 0,1 with fetchEn=1 (FETCH): vramAddr=fetchAddr, nvramOE=0, nvramWE=1, vramDataOE=0.
  - Edge ending seq 1: fetchData<=vramDataIn.
  - fetchValid=1 during seq 2 only.
- seq 2 (TURN): nvramOE=1, nvramWE=1, vramDataOE=0, vramAddr held.
- Write slot A at seq 3-5:
  - Edge ending seq 2: if FIFO non-empty, pop head into the write register.
  - seq 3 (WSETUP): addr/data driven, vramDataOE=1, nvramWE=1.
  - seq 4 (WSTROBE): nvramWE=0.
  - seq 5 (WHOLD): nvramWE=1, data still driven.
- Write slot B at seq 6, 7, 0: same as slot A, with the pop at the edge ending seq 5. Its WHOLD falls in seq 0.
- fetchEn=0: no FETCH, fetchValid stays 0. Slot B's WHOLD occupies seq 0, then seq 1 is TURN. Max drain is still 2 writes/character.
- fetchEn is sampled at the edge ending seq 7 and is stable for the whole character.
- Empty FIFO at pop time: slot stays IDLE (all strobes deasserted, vramDataOE=0).
- Push: wrReq=1 and wrFull=0 -> entry appended on that edge.
- Overflow: wrReq=1 and wrFull=1 -> request dropped, ovfFlag<=1. ovfFlag clears only on reset.
- Push and pop on the same edge: both take effect, level unchanged. wrFull reflects the level after the edge.
- Push on a full FIFO with a simultaneous pop is still refused, because wrFull is registered.
- FIFO pointers wrap modulo FIFO_DEPTH. Writes leave VRAM in FIFO order.
- Reset mid-write: strobes deassert on the next edge; popped and queued entries are discarded.

Optional Feature:
- Macro: VRAM_COALESCE_EN.
- Defined: a push whose wrAddr equals the address of the newest not-yet-popped entry overwrites that entry's data.
  - Level unchanged.
  - Accepted even when wrFull=1; ovfFlag not set for it.
  - Coalescing is not allowed against an entry being popped on the same edge; that push becomes a normal append.
- Undefined: every accepted push appends a new entry.

Test Plan:
- Reset, then 8 idle cycles -> nvramWE=1, nvramOE=1, vramDataOE=0, wrFull=0, ovfFlag=0 throughout.
- fetchEn=1, fetchAddr=15'h2700, vramDataIn=8'hA5 -> nvramOE=0 with vramAddr=15'h2700 during seq 0-1; fetchData=8'hA5 and fetchValid=1 during seq 2 only.
- Push (15'h0010, 8'h3C) at seq 1 -> vramAddr=15'h0010, vramDataOut=8'h3C, vramDataOE=1 during seq 3-5; nvramWE=0 only during seq 4.
- Push 5 entries back-to-back with FIFO_DEPTH=4 -> wrFull=1 after 4th; 5th dropped, ovfFlag=1; the 4 entries drain over 2 characters in push order.
- fetchEn=0 with 2 queued entries -> no nvramOE assertion; both entries written (nvramWE=0 at seq 4 and seq 7) within one character.
- VRAM_COALESCE_EN defined: push (15'h0020, 8'h11) then (15'h0020, 8'h22) before pop -> single write of 8'h22. Undefined: two writes, 8'h11 then 8'h22.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM port scheduler: display fetch owns seq 0-1, two FIFO-fed CPU write slots per character.
// Build option VRAM_COALESCE_EN merges a push into the newest queued entry with the same address.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8
) (
  input  logic              pixClock,
  input  logic              reset,
  input  logic [2:0]        seq,
  input  logic              fetchEn,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic [DATA_W-1:0] fetchData,
  output logic              fetchValid,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrFull,
  output logic              ovfFlag,
  output logic [ADDR_W-1:0] vramAddr,
  output logic [DATA_W-1:0] vramDataOut,
  output logic              vramDataOE,
  input  logic [DATA_W-1:0] vramDataIn,
  output logic              nvramWE,
  output logic              nvramOE,
  output logic [2:0]        dbgState
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    TURN    = 3'd2,
    WSETUP  = 3'd3,
    WSTROBE = 3'd4,
    WHOLD   = 3'd5
  } state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] memAddr [FIFO_DEPTH];
  logic [DATA_W-1:0] memData [FIFO_DEPTH];
  logic [PW-1:0]     rdPtr, wrPtr;
  logic [PW:0]       level, levelNext;
  logic              fetchEnQ;
  logic [ADDR_W-1:0] fetchAddrQ;
  logic              slotValid, slotValidNext;
  logic [2:0]        nextSeq;
  logic              fetchActive, doPop, doPush, doMerge;

`ifdef VRAM_COALESCE_EN
  logic [PW-1:0]     newestIdx;
  assign newestIdx = wrPtr - PW'(1);
`endif

  assign dbgState = state;

  // Write handshake: wrReq is valid, !wrFull is ready; a push is taken on any edge with both high.
  // Outputs are registered, so everything is decoded for the seq value of the coming cycle.
  always_comb begin
    nextSeq     = seq + 3'd1;
    fetchActive = (seq == 3'd7) ? fetchEn : fetchEnQ;
    doPop       = ((nextSeq == 3'd3) || (nextSeq == 3'd6)) && (level != '0);
`ifdef VRAM_COALESCE_EN
    doMerge     = wrReq && (level != '0) && (memAddr[newestIdx] == wrAddr) &&
                  !(doPop && (level == (PW+1)'(1)));
`else
    doMerge     = 1'b0;
`endif
    doPush      = wrReq && !wrFull && !doMerge;
    levelNext   = level + (PW+1)'(doPush) - (PW+1)'(doPop);

    stateNext     = IDLE;
    slotValidNext = 1'b0;
    case (nextSeq)
      3'd0: begin
        // Display fetch wins seq 0; slot B's hold only appears when the display is blanked.
        if (fetchActive) begin
          stateNext = FETCH;
        end else if (slotValid) begin
          stateNext     = WHOLD;
          slotValidNext = 1'b1;
        end
      end
      3'd1: stateNext = fetchActive ? FETCH : TURN;
      3'd2: stateNext = TURN;
      3'd3, 3'd6: begin
        if (doPop) begin
          stateNext     = WSETUP;
          slotValidNext = 1'b1;
        end
      end
      3'd4, 3'd7: begin
        if (slotValid) begin
          stateNext     = WSTROBE;
          slotValidNext = 1'b1;
        end
      end
      3'd5: begin
        if (slotValid) begin
          stateNext     = WHOLD;
          slotValidNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pixClock) begin
    if (reset) begin
      state       <= IDLE;
      slotValid   <= 1'b0;
      vramAddr    <= '0;
      vramDataOut <= '0;
      vramDataOE  <= 1'b0;
      nvramWE     <= 1'b1;
      nvramOE     <= 1'b1;
      fetchData   <= '0;
      fetchValid  <= 1'b0;
      fetchEnQ    <= 1'b0;
      fetchAddrQ  <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      level       <= '0;
      wrFull      <= 1'b0;
      ovfFlag     <= 1'b0;
    end else begin
      state     <= stateNext;
      slotValid <= slotValidNext;

      if (seq == 3'd7) begin
        fetchEnQ   <= fetchEn;
        fetchAddrQ <= fetchAddr;
      end

      fetchValid <= (state == FETCH) && (seq == 3'd1);
      if ((state == FETCH) && (seq == 3'd1)) begin
        fetchData <= vramDataIn;
      end

      nvramOE    <= (stateNext != FETCH);
      nvramWE    <= (stateNext != WSTROBE);
      vramDataOE <= (stateNext == WSETUP) || (stateNext == WSTROBE) || (stateNext == WHOLD);

      if (stateNext == FETCH) begin
        vramAddr <= (seq == 3'd7) ? fetchAddr : fetchAddrQ;
      end else if (stateNext == WSETUP) begin
        vramAddr    <= memAddr[rdPtr];
        vramDataOut <= memData[rdPtr];
      end

      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      if (doPush) begin
        wrPtr <= wrPtr + PW'(1);
      end
      level  <= levelNext;
      wrFull <= (levelNext == (PW+1)'(FIFO_DEPTH));
      if (wrReq && wrFull && !doMerge) begin
        ovfFlag <= 1'b1;
      end
    end
  end

  // Queue storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge pixClock) begin
    if (!reset) begin
      if (doPush) begin
        memAddr[wrPtr] <= wrAddr;
        memData[wrPtr] <= wrData;
      end
`ifdef VRAM_COALESCE_EN
      else if (doMerge) begin
        memData[newestIdx] <= wrData;
      end
`endif
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then randomized traffic against a queue-based model.
module tb_vram_arbiter;

  localparam int D  = 4;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          pixClock;
  logic          reset;
  logic [2:0]    seq;
  logic          fetchEn;
  logic [AW-1:0] fetchAddr;
  logic [DW-1:0] fetchData;
  logic          fetchValid;
  logic          wrReq;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          wrFull;
  logic          ovfFlag;
  logic [AW-1:0] vramAddr;
  logic [DW-1:0] vramDataOut;
  logic          vramDataOE;
  logic [DW-1:0] vramDataIn;
  logic          nvramWE;
  logic          nvramOE;
  logic [2:0]    dbgState;

  vram_arbiter #(.FIFO_DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
    .pixClock(pixClock), .reset(reset), .seq(seq), .fetchEn(fetchEn),
    .fetchAddr(fetchAddr), .fetchData(fetchData), .fetchValid(fetchValid),
    .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrFull(wrFull),
    .ovfFlag(ovfFlag), .vramAddr(vramAddr), .vramDataOut(vramDataOut),
    .vramDataOE(vramDataOE), .vramDataIn(vramDataIn), .nvramWE(nvramWE),
    .nvramOE(nvramOE), .dbgState(dbgState)
  );

  // clock / reset
  initial pixClock = 1'b0;
  always #20 pixClock = ~pixClock;

  // driver state
  logic          dReset, dReq, dFetchEn, dRandIn;
  logic [AW-1:0] dAddr, dFetchAddr;
  logic [DW-1:0] dData, dDataIn;
  logic [2:0]    curSeq;

  // reference model: pending writes in push order, plus the write slot in flight
  logic [AW+DW-1:0] exp_q[$];
  logic          mFull, mOvf, mFetch, mSlotValid, mFetchValid;
  logic [AW-1:0] mFetchAddr, mSlotAddr;
  logic [DW-1:0] mSlotData, mFetchData;

  // observed write strobes
  logic [AW+DW-1:0] obsLog[$];
  int            obsSeq[$];
  int            oeLow;

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic checkOutputs(input logic inReset);
    logic [2:0]    n;
    logic          expOE, expWE, expDOE, chkAddr, chkData;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expData;
    n = curSeq;
    expOE = 1'b1; expWE = 1'b1; expDOE = 1'b0;
    chkAddr = 1'b0; chkData = 1'b0; expAddr = '0; expData = '0;
    if (inReset) begin
      chkAddr = 1'b1;
      chkData = 1'b1;
    end else if (mFetch && (n == 3'd0 || n == 3'd1)) begin
      expOE = 1'b0; chkAddr = 1'b1; expAddr = mFetchAddr;
    end else if (mSlotValid && n != 3'd1 && n != 3'd2) begin
      expDOE = 1'b1;
      expWE = !(n == 3'd4 || n == 3'd7);
      chkAddr = 1'b1; expAddr = mSlotAddr;
      chkData = 1'b1; expData = mSlotData;
    end
    chk("nvramOE", 32'(nvramOE), 32'(expOE));
    chk("nvramWE", 32'(nvramWE), 32'(expWE));
    chk("vramDataOE", 32'(vramDataOE), 32'(expDOE));
    if (chkAddr) chk("vramAddr", 32'(vramAddr), 32'(expAddr));
    if (chkData) chk("vramDataOut", 32'(vramDataOut), 32'(expData));
    chk("fetchValid", 32'(fetchValid), 32'(inReset ? 1'b0 : mFetchValid));
    chk("fetchData", 32'(fetchData), 32'(mFetchData));
    chk("wrFull", 32'(wrFull), 32'(mFull));
    chk("ovfFlag", 32'(ovfFlag), 32'(mOvf));
    if (nvramWE === 1'b0) begin
      obsLog.push_back({vramAddr, vramDataOut});
      obsSeq.push_back(int'(curSeq));
    end
    if (nvramOE === 1'b0) oeLow++;
  endtask

  // one pixClock: drive at negedge, update model at posedge, check at next negedge
  task automatic step();
    logic             popNow, merged;
    logic [AW+DW-1:0] ent;
    seq = curSeq; reset = dReset; wrReq = dReq; wrAddr = dAddr; wrData = dData;
    fetchEn = dFetchEn; fetchAddr = dFetchAddr;
    vramDataIn = dRandIn ? DW'($urandom) : dDataIn;
    @(posedge pixClock);
    if (dReset) begin
      exp_q.delete();
      mFull = 1'b0; mOvf = 1'b0; mFetch = 1'b0; mSlotValid = 1'b0;
      mFetchValid = 1'b0; mFetchData = '0;
    end else begin
      mFetchValid = (curSeq == 3'd1) && mFetch;
      if (mFetchValid) mFetchData = vramDataIn;
      if (curSeq == 3'd7) begin
        mFetch = fetchEn;
        mFetchAddr = fetchAddr;
      end
      popNow = (curSeq == 3'd2) || (curSeq == 3'd5);
      merged = 1'b0;
`ifdef VRAM_COALESCE_EN
      if (wrReq && exp_q.size() > 0 && !(popNow && exp_q.size() == 1)) begin
        ent = exp_q[exp_q.size()-1];
        if (ent[AW+DW-1:DW] == wrAddr) begin
          ent[DW-1:0] = wrData;
          exp_q[exp_q.size()-1] = ent;
          merged = 1'b1;
        end
      end
`endif
      if (popNow) begin
        if (exp_q.size() > 0) begin
          ent = exp_q.pop_front();
          mSlotAddr = ent[AW+DW-1:DW];
          mSlotData = ent[DW-1:0];
          mSlotValid = 1'b1;
        end else begin
          mSlotValid = 1'b0;
        end
      end
      if (wrReq && !merged) begin
        if (mFull) mOvf = 1'b1;
        else exp_q.push_back({wrAddr, wrData});
      end
      mFull = (exp_q.size() == D);
    end
    @(negedge pixClock);
    curSeq = curSeq + 3'd1;
    checkOutputs(dReset);
  endtask

  task automatic runTo(input logic [2:0] s);
    for (int k = 0; k < 8 && curSeq != s; k++) step();
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    dReq = 1'b1; dAddr = a; dData = d;
    step();
    dReq = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; oeLow = 0;
    curSeq = 3'd0;
    dReset = 1'b1; dReq = 1'b0; dFetchEn = 1'b0; dRandIn = 1'b1;
    dAddr = '0; dData = '0; dFetchAddr = '0; dDataIn = '0;
    mFull = 1'b0; mOvf = 1'b0; mFetch = 1'b0; mSlotValid = 1'b0; mFetchValid = 1'b0;
    mFetchAddr = '0; mSlotAddr = '0; mSlotData = '0; mFetchData = '0;

    // reset, then idle
    repeat (4) step();
    dReset = 1'b0;
    repeat (8) step();

    // display fetch with a fixed read value
    dFetchEn = 1'b1; dFetchAddr = 15'h2700; dRandIn = 1'b0; dDataIn = 8'hA5;
    runTo(3'd7);
    step();
    runTo(3'd2);
    chk("fetchValidSeq2", 32'(fetchValid), 32'd1);
    chk("fetchDataA5", 32'(fetchData), 32'h00A5);
    dRandIn = 1'b1;

    // single write queued at seq 1
    runTo(3'd1);
    obsLog.delete();
    push(15'h0010, 8'h3C);
    runTo(3'd6);
    chk("singleWriteCount", 32'(obsLog.size()), 32'd1);
    chk("singleWrite", 32'(obsLog[0]), 32'({15'h0010, 8'h3C}));

    // fill to full, fifth push refused even though a pop lands on the same edge
    obsLog.delete();
    for (int i = 0; i < 5; i++) begin
      push(AW'(32'h100 + i), DW'(32'h50 + i));
      if (i == 3) chk("wrFullAfter4", 32'(wrFull), 32'd1);
    end
    chk("ovfAfter5", 32'(ovfFlag), 32'd1);
    repeat (16) step();
    chk("drainCount", 32'(obsLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("drainOrder", 32'(obsLog[i]), 32'({AW'(32'h100 + i), DW'(32'h50 + i)}));

    // blanked display: no fetch, both slots used in one character
    dFetchEn = 1'b0;
    runTo(3'd7);
    step();
    obsLog.delete(); obsSeq.delete(); oeLow = 0;
    push(15'h0200, 8'hC1);
    push(15'h0201, 8'hC2);
    repeat (7) step();
    chk("blankOeLow", 32'(oeLow), 32'd0);
    chk("blankWrites", 32'(obsLog.size()), 32'd2);
    chk("blankSeqA", 32'(obsSeq[0]), 32'd4);
    chk("blankSeqB", 32'(obsSeq[1]), 32'd7);
    chk("blankDataA", 32'(obsLog[0]), 32'({15'h0200, 8'hC1}));
    chk("blankDataB", 32'(obsLog[1]), 32'({15'h0201, 8'hC2}));

    // same-address pushes before the pop
    runTo(3'd0);
    obsLog.delete();
    push(15'h0020, 8'h11);
    push(15'h0020, 8'h22);
    repeat (8) step();
`ifdef VRAM_COALESCE_EN
    chk("mergeCount", 32'(obsLog.size()), 32'd1);
    chk("mergeData", 32'(obsLog[0]), 32'({15'h0020, 8'h22}));
`else
    chk("mergeCount", 32'(obsLog.size()), 32'd2);
    chk("mergeFirst", 32'(obsLog[0]), 32'({15'h0020, 8'h11}));
    chk("mergeSecond", 32'(obsLog[1]), 32'({15'h0020, 8'h22}));
`endif

    // same-address push on the edge that pops the only entry is a plain append
    runTo(3'd1);
    obsLog.delete();
    push(15'h0030, 8'h33);
    push(15'h0030, 8'h44);
    repeat (8) step();
    chk("popRaceCount", 32'(obsLog.size()), 32'd2);
    chk("popRaceFirst", 32'(obsLog[0]), 32'({15'h0030, 8'h33}));
    chk("popRaceSecond", 32'(obsLog[1]), 32'({15'h0030, 8'h44}));

    // randomized traffic with one mid-character reset
    for (int c = 0; c < 800; c++) begin
      if (curSeq == 3'd7) begin
        dFetchEn = 1'($urandom_range(0, 1));
        dFetchAddr = AW'($urandom);
      end
      dReset = (c == 400 || c == 401);
      dReq = !dReset && ($urandom_range(0, 99) < 45);
      dAddr = AW'(32'h40 + $urandom_range(0, 3));
      dData = DW'($urandom);
      step();
    end
    dReset = 1'b0; dReq = 1'b0;
    repeat (16) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
